// File: rtl/core_frame_loader_pkg.sv
// Shared definitions for the per-core instruction-frame loader.
//   - state_t : loader FSM state encoding (2-bit)
//   - width_of: clog2 clamped to a minimum of 1 bit, so a one-beat frame
//               still yields a legal counter width
// Optional build macro used by the loader: CORE_FRAME_LOADER_CHECK_EN
package core_frame_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_frame_buf.sv
// Local frame buffer: FRAME_INSNS slots of INSN_W bits.
// Ports:
//   clk        in  clock, rising edge
//   clr_n      in  synchronous active-low clear (all slots to 0)
//   we         in  beat write strobe
//   beat_idx   in  beat index; writes slots beat_idx*LANES .. +LANES-1
//   beat_data  in  beat payload, lane j in bits [j*INSN_W +: INSN_W]
//   rd_addr    in  read slot index
//   rd_data    out slot contents, combinational read
// Each slot is its own register: a whole beat lands in one cycle and the
// fetch stage reads combinationally, which a block RAM cannot provide.
module core_frame_buf
    import core_frame_loader_pkg::*;
#(
    parameter int INSN_LOAD_TIME = 4,
    parameter int INSN_W         = 16,
    parameter int LANES          = 4,
    parameter int CNT_W          = 2,
    parameter int ADDR_W         = 4
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      we,
    input  logic [CNT_W-1:0]          beat_idx,
    input  logic [LANES*INSN_W-1:0]   beat_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [INSN_W-1:0]         rd_data
);

    localparam int FRAME_INSNS = INSN_LOAD_TIME * LANES;

    logic [FRAME_INSNS*INSN_W-1:0] slots_flat;

    generate
        for (genvar gi = 0; gi < FRAME_INSNS; gi++) begin : g_slot
            logic [INSN_W-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    slot_reg <= '0;
                end else if (we && (beat_idx == CNT_W'(gi / LANES))) begin
                    slot_reg <= beat_data[(gi % LANES)*INSN_W +: INSN_W];
                end
            end

            assign slots_flat[gi*INSN_W +: INSN_W] = slot_reg;
        end
    endgenerate

    // Out-of-range addresses (non power-of-two frames) read as zero.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < (ADDR_W+1)'(FRAME_INSNS)) begin
            rd_data = slots_flat[rd_addr*INSN_W +: INSN_W];
        end
    end

endmodule

// File: rtl/core_frame_loader.sv
// Per-core receiver for the scheduler's instruction-frame broadcast.
// Collects INSN_LOAD_TIME beats into the local frame buffer, then launches
// execution (one-cycle exec_go, optional R0 write) and holds ready low until
// the core reports exec_done.
// Ports:
//   clk, reset (sync, active-low)
//   start, insn_load_counter, insn_data : scheduler beat bus
//   init_r0_en, init_r0                 : R0 initialisation for the frame
//   ready                               : 1 = idle or loading
//   exec_go                             : launch pulse
//   exec_done                           : core finished the frame
//   fetch_addr / fetch_insn             : combinational buffer read
//   r0_we / r0_wdata                    : R0 write to the register file
//   err                                 : sticky protocol error
// Build option: CORE_FRAME_LOADER_CHECK_EN enables the protocol checker;
// when undefined err is tied to 0.
module core_frame_loader
    import core_frame_loader_pkg::*;
#(
    parameter int INSN_LOAD_TIME = 4,
    parameter int INSN_BUS_W     = 64,
    parameter int INSN_W         = 16,
    parameter int REG_W          = 8,
    localparam int LANES         = INSN_BUS_W / INSN_W,
    localparam int FRAME_INSNS   = INSN_LOAD_TIME * LANES,
    localparam int CNT_W         = width_of(INSN_LOAD_TIME),
    localparam int ADDR_W        = width_of(FRAME_INSNS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      insn_load_counter,
    input  logic [INSN_BUS_W-1:0] insn_data,
    input  logic                  init_r0_en,
    input  logic [REG_W-1:0]      init_r0,
    output logic                  ready,
    output logic                  exec_go,
    input  logic                  exec_done,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic [INSN_W-1:0]     fetch_insn,
    output logic                  r0_we,
    output logic [REG_W-1:0]      r0_wdata,
    output logic                  err
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(INSN_LOAD_TIME - 1);

    state_t             state_reg, state_next;
    logic               beat;
    logic               r0_en_reg;
    logic [REG_W-1:0]   r0_val_reg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outputs depend on state_reg only, so ready drops the cycle after the
    // last beat and the scheduler cannot start another frame on this core.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        exec_go    = 1'b0;
        r0_we      = 1'b0;
        r0_wdata   = '0;
        beat       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                beat  = start;
                if (start && insn_load_counter == '0) begin
                    state_next = (INSN_LOAD_TIME == 1) ? ST_LAUNCH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready = 1'b1;
                beat  = start;
                if (start && insn_load_counter == LAST_BEAT) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                exec_go    = 1'b1;
                r0_we      = r0_en_reg;
                r0_wdata   = r0_val_reg;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // R0 request is captured with the frame's first beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r0_en_reg  <= 1'b0;
            r0_val_reg <= '0;
        end else if (state_reg == ST_IDLE && start && insn_load_counter == '0) begin
            r0_en_reg  <= init_r0_en;
            r0_val_reg <= init_r0;
        end
    end

    // ---------------- frame buffer ----------------
    core_frame_buf #(
        .INSN_LOAD_TIME (INSN_LOAD_TIME),
        .INSN_W         (INSN_W),
        .LANES          (LANES),
        .CNT_W          (CNT_W),
        .ADDR_W         (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .clr_n     (reset),
        .we        (beat),
        .beat_idx  (insn_load_counter),
        .beat_data (insn_data),
        .rd_addr   (fetch_addr),
        .rd_data   (fetch_insn)
    );

    // ---------------- protocol checker ----------------
`ifdef CORE_FRAME_LOADER_CHECK_EN
    logic [CNT_W-1:0] exp_reg;
    logic             err_reg;
    logic             proto_err;

    always_comb begin
        proto_err = 1'b0;
        if (beat && insn_load_counter != exp_reg) begin
            proto_err = 1'b1;
        end
        if (start && (state_reg == ST_LAUNCH || state_reg == ST_EXEC)) begin
            proto_err = 1'b1;
        end
        if (beat && state_reg == ST_LOAD && insn_load_counter == '0) begin
            proto_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            // The expected index restarts once the frame completes.
            if (beat && state_next == ST_LAUNCH) begin
                exp_reg <= '0;
            end else if (beat) begin
                exp_reg <= exp_reg + 1'b1;
            end
            if (proto_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_core_frame_loader.sv
// Directed self-checking bench for core_frame_loader (default 4x64/16 config).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_core_frame_loader;

    localparam int LT     = 4;
    localparam int BUS_W  = 64;
    localparam int IW     = 16;
    localparam int RW     = 8;
    localparam int NSLOT  = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      insn_load_counter = '0;
    logic [BUS_W-1:0] insn_data = '0;
    logic            init_r0_en = 1'b0;
    logic [RW-1:0]   init_r0 = '0;
    logic            ready;
    logic            exec_go;
    logic            exec_done = 1'b0;
    logic [3:0]      fetch_addr = '0;
    logic [IW-1:0]   fetch_insn;
    logic            r0_we;
    logic [RW-1:0]   r0_wdata;
    logic            err;

    int vectors = 0;
    int miscompares = 0;

`ifdef CORE_FRAME_LOADER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    core_frame_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .insn_load_counter (insn_load_counter),
        .insn_data         (insn_data),
        .init_r0_en        (init_r0_en),
        .init_r0           (init_r0),
        .ready             (ready),
        .exec_go           (exec_go),
        .exec_done         (exec_done),
        .fetch_addr        (fetch_addr),
        .fetch_insn        (fetch_insn),
        .r0_we             (r0_we),
        .r0_wdata          (r0_wdata),
        .err               (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [1:0] cnt, input logic [BUS_W-1:0] data);
        start = 1'b1;
        insn_load_counter = cnt;
        insn_data = data;
        tick();
        start = 1'b0;
    endtask

    // Beat k of a frame whose slot s holds base+s.
    function automatic logic [BUS_W-1:0] frame_beat(input logic [IW-1:0] base, input int k);
        logic [BUS_W-1:0] d;
        for (int j = 0; j < 4; j++) begin
            d[j*IW +: IW] = base + IW'(k*4 + j);
        end
        return d;
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b0;
        start = 1'b0;
        exec_done = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        $display("reset: 3 cycles held, released");
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", ready); end
        vectors++;
        if (exec_go !== 1'b0) begin miscompares++; $display("FAIL reset_exec_go got %b exp 0", exec_go); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
        vectors++;
        if (r0_we !== 1'b0 || r0_wdata !== 8'h00) begin
            miscompares++; $display("FAIL reset_r0 got we=%b d=%h exp 0/00", r0_we, r0_wdata);
        end
        vectors++;
        for (int i = 0; i < NSLOT; i++) begin
            fetch_addr = 4'(i);
            #1;
            if (fetch_insn !== 16'h0000) begin
                miscompares++; $display("FAIL reset_slot%0d got %h exp 0000", i, fetch_insn);
            end
            vectors++;
        end
    endtask

    task automatic test_load();
        init_r0_en = 1'b1;
        init_r0 = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            send_beat(2'(k), 64'h0003_0002_0001_0000 + 64'(k) * 64'h0004_0004_0004_0004);
            $display("load: beat %0d ready=%b exec_go=%b", k, ready, exec_go);
            if (k < 3) begin
                if (ready !== 1'b1 || exec_go !== 1'b0) begin
                    miscompares++; $display("FAIL load_mid%0d got ready=%b go=%b exp 1/0", k, ready, exec_go);
                end
                vectors++;
            end
        end
        // t+1: LAUNCH
        if (ready !== 1'b0 || exec_go !== 1'b1) begin
            miscompares++; $display("FAIL load_launch got ready=%b go=%b exp 0/1", ready, exec_go);
        end
        vectors++;
        if (r0_we !== 1'b1 || r0_wdata !== 8'h5A) begin
            miscompares++; $display("FAIL load_r0 got we=%b d=%h exp 1/5a", r0_we, r0_wdata);
        end
        vectors++;
        tick();
        // t+2: EXEC
        if (ready !== 1'b0 || exec_go !== 1'b0 || r0_we !== 1'b0) begin
            miscompares++; $display("FAIL load_exec got ready=%b go=%b we=%b exp 0/0/0", ready, exec_go, r0_we);
        end
        vectors++;
        for (int i = 0; i < NSLOT; i++) begin
            fetch_addr = 4'(i);
            #1;
            if (fetch_insn !== 16'(i)) begin
                miscompares++; $display("FAIL load_slot%0d got %h exp %h", i, fetch_insn, 16'(i));
            end
            vectors++;
        end
        tick();
        tick();
        if (ready !== 1'b0) begin miscompares++; $display("FAIL exec_hold_ready got %b exp 0", ready); end
        vectors++;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        $display("load: exec_done, ready=%b", ready);
        if (ready !== 1'b1) begin miscompares++; $display("FAIL exec_done_ready got %b exp 1", ready); end
        vectors++;
        // exec_done in IDLE is ignored
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        if (ready !== 1'b1 || exec_go !== 1'b0) begin
            miscompares++; $display("FAIL idle_done got ready=%b go=%b exp 1/0", ready, exec_go);
        end
        vectors++;
    endtask

    task automatic test_gap();
        init_r0_en = 1'b0;
        init_r0 = 8'h33;
        send_beat(2'd0, frame_beat(16'h1000, 0));
        send_beat(2'd1, frame_beat(16'h1000, 1));
        for (int g = 0; g < 2; g++) begin
            tick();
            $display("gap: idle cycle %0d ready=%b exec_go=%b", g, ready, exec_go);
            if (ready !== 1'b1 || exec_go !== 1'b0) begin
                miscompares++; $display("FAIL gap%0d got ready=%b go=%b exp 1/0", g, ready, exec_go);
            end
            vectors++;
        end
        send_beat(2'd2, frame_beat(16'h1000, 2));
        if (exec_go !== 1'b0) begin miscompares++; $display("FAIL gap_early_go got %b exp 0", exec_go); end
        vectors++;
        send_beat(2'd3, frame_beat(16'h1000, 3));
        $display("gap: after beat 3 exec_go=%b r0_we=%b", exec_go, r0_we);
        if (exec_go !== 1'b1 || ready !== 1'b0) begin
            miscompares++; $display("FAIL gap_launch got go=%b ready=%b exp 1/0", exec_go, ready);
        end
        vectors++;
        if (r0_we !== 1'b0) begin miscompares++; $display("FAIL gap_r0_we got %b exp 0", r0_we); end
        vectors++;
        tick();
        for (int i = 0; i < NSLOT; i++) begin
            fetch_addr = 4'(i);
            #1;
            if (fetch_insn !== 16'h1000 + 16'(i)) begin
                miscompares++; $display("FAIL gap_slot%0d got %h exp %h", i, fetch_insn, 16'h1000 + 16'(i));
            end
            vectors++;
        end
        // start while executing: no write, no state change
        send_beat(2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        $display("gap: start in EXEC ready=%b err=%b", ready, err);
        if (ready !== 1'b0 || exec_go !== 1'b0) begin
            miscompares++; $display("FAIL exec_start_state got ready=%b go=%b exp 0/0", ready, exec_go);
        end
        vectors++;
        if (err !== ERR_EXP) begin miscompares++; $display("FAIL exec_start_err got %b exp %b", err, ERR_EXP); end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = 4'(i);
            #1;
            if (fetch_insn !== 16'h1000 + 16'(i)) begin
                miscompares++; $display("FAIL exec_start_slot%0d got %h exp %h", i, fetch_insn, 16'h1000 + 16'(i));
            end
            vectors++;
        end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    task automatic test_bad_sequence();
        apply_reset(1);
        tick();
        if (err !== 1'b0) begin miscompares++; $display("FAIL seq_err_pre got %b exp 0", err); end
        vectors++;
        send_beat(2'd0, frame_beat(16'h2000, 0));
        send_beat(2'd2, frame_beat(16'h2000, 2));
        $display("seq: beats 0,2 err=%b", err);
        if (err !== ERR_EXP) begin miscompares++; $display("FAIL seq_err got %b exp %b", err, ERR_EXP); end
        vectors++;
        tick();
        tick();
        if (err !== ERR_EXP) begin miscompares++; $display("FAIL seq_err_sticky got %b exp %b", err, ERR_EXP); end
        vectors++;
        // Offending beat is still written at its given index (slots 8..11).
        fetch_addr = 4'd9;
        #1;
        if (fetch_insn !== 16'h2009) begin miscompares++; $display("FAIL seq_slot9 got %h exp 2009", fetch_insn); end
        vectors++;
    endtask

    task automatic test_reset_mid();
        apply_reset(1);
        tick();
        init_r0_en = 1'b1;
        init_r0 = 8'hC3;
        send_beat(2'd0, frame_beat(16'h3000, 0));
        send_beat(2'd1, frame_beat(16'h3000, 1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        $display("mid-reset: ready=%b err=%b", ready, err);
        if (ready !== 1'b1 || err !== 1'b0) begin
            miscompares++; $display("FAIL midrst_state got ready=%b err=%b exp 1/0", ready, err);
        end
        vectors++;
        for (int i = 0; i < 8; i++) begin
            fetch_addr = 4'(i);
            #1;
            if (fetch_insn !== 16'h0000) begin
                miscompares++; $display("FAIL midrst_slot%0d got %h exp 0000", i, fetch_insn);
            end
            vectors++;
        end
        // A beat with counter 2 would complete nothing now: a fresh load is needed.
        for (int k = 0; k < 4; k++) begin
            send_beat(2'(k), frame_beat(16'h4000, k));
        end
        $display("mid-reset: fresh load exec_go=%b r0_we=%b r0_wdata=%h", exec_go, r0_we, r0_wdata);
        if (exec_go !== 1'b1 || r0_we !== 1'b1 || r0_wdata !== 8'hC3) begin
            miscompares++; $display("FAIL midrst_launch got go=%b we=%b d=%h exp 1/1/c3", exec_go, r0_we, r0_wdata);
        end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err got %b exp 0", err); end
        vectors++;
        for (int i = 0; i < NSLOT; i += 5) begin
            fetch_addr = 4'(i);
            #1;
            if (fetch_insn !== 16'h4000 + 16'(i)) begin
                miscompares++; $display("FAIL midrst_slot_new%0d got %h exp %h", i, fetch_insn, 16'h4000 + 16'(i));
            end
            vectors++;
        end
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL midrst_done got %b exp 1", ready); end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_gap();
        test_bad_sequence();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
